// File: rtl/regfile_pkg.sv
// Shared types, default sizes and write-port priority helper for the register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int NWR_MAX   = 4;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

    // Index of the highest set bit of en, or -1 when no bit is set.
    function automatic int onehot_last(input logic [NWR_MAX-1:0] en);
        int w;
        w = -1;
        for (int k = 0; k < NWR_MAX; k++) begin
            if (en[k]) begin
                w = k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags with reserve handshake; busy queries are combinational.
// Reservation wins over a same-cycle clear; reserving a busy register stalls (rsv_ready low).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 1,
    parameter int NQ    = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rsv_valid,
    input  logic [AW-1:0]           rsv_addr,
    output logic                    rsv_ready,
    input  logic [NWR-1:0]          clr,
    input  logic [NWR-1:0][AW-1:0]  clr_addr,
    input  logic [NQ-1:0][AW-1:0]   query_addr,
    output logic [NQ-1:0]           query_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // The handshake looks only at registered state, never at same-cycle clears.
    assign rsv_ready = rsv_valid && !rst && !busy[rsv_addr];

    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWR; k++) begin
            if (clr[k]) begin
                busy_nxt[clr_addr[k]] = 1'b0;
            end
        end
        if (rsv_valid && !busy[rsv_addr] && rsv_addr != '0) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        query_busy = '0;
        for (int i = 0; i < NQ; i++) begin
            query_busy[i] = busy[query_addr[i]];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with async reset, optional write-to-read bypass and busy scoreboard.
// Reads are zero latency; writes land on the clock edge; reservations stall while the target is busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [NWR-1:0]           wr_clr,
    input  logic                     rsv_valid,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     rsv_ready
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NWR-1:0]  wr_win;
    logic [NRD-1:0]  sb_busy;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .NQ    (NRD)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ready  (rsv_ready),
        .clr        (wr_en & wr_clr),
        .clr_addr   (wr_addr),
        .query_addr (rd_addr),
        .query_busy (sb_busy)
    );

    // A port commits only if no higher-indexed enabled port targets the same register.
    always_comb begin
        logic [NWR_MAX-1:0] m;
        wr_win = '0;
        m      = '0;
        for (int k = 0; k < NWR; k++) begin
            m = '0;
            for (int j = 0; j < NWR; j++) begin
                m[j] = wr_en[j] && (wr_addr[j] == wr_addr[k]);
            end
            wr_win[k] = (onehot_last(m) == k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_win[k] && wr_addr[k] != '0) begin
                    regs[wr_addr[k]] <= wr_data[k];
                end
            end
        end
    end

    always_comb begin
        logic [NWR_MAX-1:0] hit;
        int                 w;
        rd_data = '0;
        rd_busy = '0;
        hit     = '0;
        w       = -1;
        for (int i = 0; i < NRD; i++) begin
            hit = '0;
            for (int k = 0; k < NWR; k++) begin
                hit[k] = wr_en[k] && (wr_addr[k] == rd_addr[i]);
            end
            w = onehot_last(hit);
            rd_data[i] = regs[rd_addr[i]];
            rd_busy[i] = sb_busy[i];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (w == k) begin
                        rd_data[i] = wr_data[k];
                        if (wr_clr[k]) begin
                            rd_busy[i] = 1'b0;
                        end
                    end
                end
            end
            // x0 is hardwired zero and reset masks any forwarded write data.
            if (rst || rd_addr[i] == '0) begin
                rd_data[i] = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two register files (bypass on/off) share stimulus and are checked against a reference model.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [1:0][4:0]       rd_addr;
    logic [1:0][31:0]      rd_data_b, rd_data_n;
    logic [1:0]            rd_busy_b, rd_busy_n;
    logic [1:0]            wr_en;
    logic [1:0][4:0]       wr_addr;
    logic [1:0][31:0]      wr_data;
    logic [1:0]            wr_clr;
    logic                  rsv_valid;
    logic [4:0]            rsv_addr;
    logic                  rsv_ready_b, rsv_ready_n;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_b)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_n)
    );

    typedef struct packed {
        logic [31:0]      tag;
        logic [1:0][31:0] db;
        logic [1:0][31:0] dn;
        logic [1:0]       bb;
        logic [1:0]       bn;
        logic             rdy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ncyc = 0;
    logic        last_rdy = 1'b0;

    // Reference model: architectural contents and pending-write flags.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    // Stimulus for the next cycle.
    logic            s_rst;
    reg_addr_t [1:0] s_rd_addr;
    logic [1:0]      s_wr_en;
    reg_addr_t [1:0] s_wr_addr;
    reg_data_t [1:0] s_wr_data;
    logic [1:0]      s_wr_clr;
    logic            s_rsv_valid;
    reg_addr_t       s_rsv_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] tag,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, tag, act, req);
        end
    endtask

    task automatic idle();
        s_rst = 1'b0; s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0;
        s_wr_data = '0; s_wr_clr = '0; s_rsv_valid = 1'b0; s_rsv_addr = '0;
    endtask

    task automatic step();
        exp_t       e;
        logic [4:0] a;
        @(negedge clk);
        rst = s_rst; rd_addr = s_rd_addr; wr_en = s_wr_en; wr_addr = s_wr_addr;
        wr_data = s_wr_data; wr_clr = s_wr_clr; rsv_valid = s_rsv_valid; rsv_addr = s_rsv_addr;
        e = '0;
        e.tag = ncyc;
        if (s_rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                a = s_rd_addr[i];
                if (a != 0) begin
                    e.dn[i] = m_regs[a];
                    e.bn[i] = m_busy[a];
                    e.db[i] = m_regs[a];
                    e.bb[i] = m_busy[a];
                    for (int k = 0; k < 2; k++) begin
                        if (s_wr_en[k] && s_wr_addr[k] == a) begin
                            e.db[i] = s_wr_data[k];
                            e.bb[i] = m_busy[a] && !s_wr_clr[k];
                        end
                    end
                end
            end
            e.rdy = s_rsv_valid && !m_busy[s_rsv_addr];
            for (int k = 0; k < 2; k++)
                if (s_wr_en[k] && s_wr_addr[k] != 0) m_regs[s_wr_addr[k]] = s_wr_data[k];
            for (int k = 0; k < 2; k++)
                if (s_wr_en[k] && s_wr_clr[k]) m_busy[s_wr_addr[k]] = 1'b0;
            if (e.rdy && s_rsv_addr != 0) m_busy[s_rsv_addr] = 1'b1;
        end
        last_rdy = e.rdy;
        exp_q.push_back(e);
        ncyc++;
    endtask

    // Monitor: checks the combinational outputs shortly after the inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("rd_data_byp[%0d]", i), e.tag, rd_data_b[i], e.db[i]);
                    chk($sformatf("rd_data_nob[%0d]", i), e.tag, rd_data_n[i], e.dn[i]);
                    chk($sformatf("rd_busy_byp[%0d]", i), e.tag, 32'(rd_busy_b[i]), 32'(e.bb[i]));
                    chk($sformatf("rd_busy_nob[%0d]", i), e.tag, 32'(rd_busy_n[i]), 32'(e.bn[i]));
                end
                chk("rsv_ready_byp", e.tag, 32'(rsv_ready_b), 32'(e.rdy));
                chk("rsv_ready_nob", e.tag, 32'(rsv_ready_n), 32'(e.rdy));
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        wr_clr = '0; rsv_valid = 1'b0; rsv_addr = '0;
        idle();

        // Reset state
        s_rst = 1'b1; s_rd_addr[0] = 5'd3; s_rsv_valid = 1'b1; s_rsv_addr = 5'd3;
        step(); step();

        // Bypass and x0 writes
        idle(); s_wr_en = 2'b01; s_wr_addr[0] = 5'd3; s_wr_data[0] = 32'h1111_1111; step();
        idle(); s_wr_en = 2'b11; s_wr_addr[0] = 5'd3; s_wr_data[0] = 32'h1234_5678;
        s_wr_addr[1] = 5'd0; s_wr_data[1] = 32'hFFFF_FFFF; s_rd_addr[0] = 5'd3; s_rd_addr[1] = 5'd0; step();
        idle(); s_rd_addr[0] = 5'd3; s_rd_addr[1] = 5'd0; step();

        // Write collision on x7
        idle(); s_wr_en = 2'b11; s_wr_addr[0] = 5'd7; s_wr_addr[1] = 5'd7;
        s_wr_data[0] = 32'h1; s_wr_data[1] = 32'h2; s_rd_addr[0] = 5'd7; step();
        idle(); s_rd_addr[0] = 5'd7; step();

        // Scoreboard stall on x9
        idle(); s_rsv_valid = 1'b1; s_rsv_addr = 5'd9; s_rd_addr[1] = 5'd9; step();
        step();
        s_wr_en = 2'b01; s_wr_addr[0] = 5'd9; s_wr_data[0] = 32'hA5; s_wr_clr = 2'b01; step();
        s_wr_en = '0; s_wr_clr = '0; step();
        idle(); s_rd_addr[1] = 5'd9; step();

        // Same-cycle clear and reserve on busy x4
        idle(); s_rsv_valid = 1'b1; s_rsv_addr = 5'd4; step();
        s_wr_en = 2'b10; s_wr_addr[1] = 5'd4; s_wr_data[1] = 32'h44; s_wr_clr = 2'b10; s_rd_addr[0] = 5'd4; step();
        s_wr_en = '0; s_wr_clr = '0; step();
        idle(); s_rd_addr[0] = 5'd4; step();

        // Clear plus accepted reserve on idle x12
        idle(); s_wr_en = 2'b01; s_wr_addr[0] = 5'd12; s_wr_data[0] = 32'hC; s_wr_clr = 2'b01;
        s_rsv_valid = 1'b1; s_rsv_addr = 5'd12; step();
        idle(); s_rd_addr[0] = 5'd12; step();

        // Reset mid-run with x5 written and reserved
        idle(); s_wr_en = 2'b01; s_wr_addr[0] = 5'd5; s_wr_data[0] = 32'hDEAD_BEEF;
        s_rsv_valid = 1'b1; s_rsv_addr = 5'd5; step();
        idle(); s_rd_addr[0] = 5'd5; s_rd_addr[1] = 5'd5; step();
        s_rst = 1'b1; step();
        s_rst = 1'b0; step();

        // Randomized traffic over a small address window to provoke hazards
        idle();
        for (int n = 0; n < 400; n++) begin
            s_rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) s_rd_addr[i] = 5'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++) begin
                s_wr_en[k]   = 1'($urandom_range(0, 1));
                s_wr_addr[k] = 5'($urandom_range(0, 7));
                s_wr_data[k] = $urandom();
                s_wr_clr[k]  = 1'($urandom_range(0, 1));
            end
            if (!(s_rsv_valid && !last_rdy)) begin
                s_rsv_valid = 1'($urandom_range(0, 1));
                s_rsv_addr  = 5'($urandom_range(0, 7));
            end
            step();
        end

        idle();
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
